// File: rtl/rv_pkg.sv
// Shared RV32I fetch-side definitions: widths, major opcodes, fetch FSM encoding
// and the {instr[30], funct3} extraction used by ALU control.
package rv_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_DROP = 2'd2
   } fetch_state_e;

   function automatic logic [3:0] funct_of(input logic [INSTR_W-1:0] word);
      return {word[30], word[14:12]};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular {pc,instr} buffer with combinational head read and synchronous flush.
// Flush beats any same-cycle write or read; write while full is accepted only alongside a read.
module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int W     = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          flush_i,
   input  logic          wr_en_i,
   input  logic [W-1:0]  wr_dat_i,
   input  logic          rd_en_i,
   output logic [W-1:0]  rd_dat_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [AW:0]   count_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         do_wr, do_rd;

   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o  = wr_ptr_q - rd_ptr_q;
   assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_rd = rd_en_i && !empty_o && !flush_i;
   assign do_wr = wr_en_i && !flush_i && (!full_o || do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: single-outstanding imem port feeding a small buffer, head
// exposed to decode via valid/ready; branch redirect flushes and drops in-flight data.
module instr_fetch_unit
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic [6:0]  opcode,
   output logic [3:0]  Funct
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] drop_addr_q, drop_addr_d;
   logic            enq, deq;
   logic            buf_empty, buf_full;
   logic [CW-1:0]   count;
   logic [CW:0]     occ_after;
   logic [63:0]     rd_dat;

   fetch_buffer #(.DEPTH(DEPTH), .W(64)) u_buf (
      .clk_i    (clk),
      .reset_i  (reset),
      .flush_i  (branch_taken),
      .wr_en_i  (enq),
      .wr_dat_i ({fetch_pc_q, imem_rdata}),
      .rd_en_i  (deq),
      .rd_dat_o (rd_dat),
      .empty_o  (buf_empty),
      .full_o   (buf_full),
      .count_o  (count)
   );

   assign dec_valid = !buf_empty;
   assign deq       = dec_valid && dec_ready;
   assign instr     = buf_empty ? '0 : rd_dat[31:0];
   assign pc_out    = buf_empty ? '0 : rd_dat[63:32];
   assign opcode    = instr[6:0];
   assign Funct     = funct_of(instr);

   // Occupancy once this cycle's ack lands, net of a same-cycle dequeue.
   assign occ_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(deq);

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      imem_req    = 1'b0;
      imem_addr   = fetch_pc_q;
      enq         = 1'b0;

      case (state_q)
         FS_IDLE: begin
            if (!buf_full) state_d = FS_REQ;
         end
         FS_REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               enq        = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = (occ_after < (CW+1)'(DEPTH)) ? FS_REQ : FS_IDLE;
            end
         end
         FS_DROP: begin
            imem_req  = 1'b1;
            imem_addr = drop_addr_q;
            if (imem_ack) state_d = FS_IDLE;
         end
         default: state_d = FS_IDLE;
      endcase

      // The open request keeps its address; only the next fetch sees the target.
      if (branch_taken) begin
         enq        = 1'b0;
         fetch_pc_d = {branch_target[31:2], 2'b00};
         case (state_q)
            FS_REQ: begin
               if (imem_ack) begin
                  state_d = FS_IDLE;
               end else begin
                  state_d     = FS_DROP;
                  drop_addr_d = fetch_pc_q;
               end
            end
            FS_DROP: state_d = FS_DROP;
            default: state_d = FS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FS_IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

endmodule
